// File: rtl/jr_hazard_ctrl_pkg.sv
// rtl/jr_hazard_ctrl_pkg.sv - shared pipeline constants for the decode-stage jr hazard controller
package jr_hazard_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] JR_FUNCT  = 6'b001000;

    // jr target source select for the decode forwarding mux
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    // stall-need encoding: number of cycles the jr must wait in D
    localparam int NEED_W = 2;
    localparam logic [NEED_W-1:0] NEED_NONE = 2'd0;
    localparam logic [NEED_W-1:0] NEED_ONE  = 2'd1;
    localparam logic [NEED_W-1:0] NEED_TWO  = 2'd2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

endpackage

// File: rtl/jr_dep_detect.sv
// rtl/jr_dep_detect.sv - combinational jr decode, producer match, stall need and forward select
module jr_dep_detect #(
    parameter int               REG_W    = 5,
    parameter int               OPF_W    = 6,
    parameter logic [OPF_W-1:0] JR_FUNCT = 6'b001000
) (
    input  logic [OPF_W-1:0] opcodeD,
    input  logic [OPF_W-1:0] functD,
    input  logic [REG_W-1:0] rsD,
    input  logic [REG_W-1:0] rdE,
    input  logic             regWriteE,
    input  logic             memReadE,
    input  logic [REG_W-1:0] rdM,
    input  logic             regWriteM,
    input  logic             memReadM,
    input  logic [REG_W-1:0] rdW,
    input  logic             regWriteW,
    output logic             is_jr,
    output logic [1:0]       need,
    output logic [1:0]       fwd_sel
);
    import jr_hazard_ctrl_pkg::*;

    logic match_e;
    logic match_m;
    logic match_w;
    logic rs_nz;

    always_comb begin
        is_jr   = (opcodeD == '0) && (functD == JR_FUNCT);
        rs_nz   = (rsD != '0);
        match_e = regWriteE && (rdE == rsD) && rs_nz;
        match_m = regWriteM && (rdM == rsD) && rs_nz;
        match_w = regWriteW && (rdW == rsD) && rs_nz;

        // A load in E needs two cycles to reach W; an ALU op in E or a load in M need one.
        need = NEED_NONE;
        if (match_e && memReadE) begin
            need = NEED_TWO;
        end else if (match_e) begin
            need = NEED_ONE;
        end else if (match_m && memReadM) begin
            need = NEED_ONE;
        end

        fwd_sel = FWD_RF;
        if (!is_jr) begin
            fwd_sel = FWD_RF;
        end else if (match_m && !memReadM) begin
            fwd_sel = FWD_M;
        end else if (match_w) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/jr_hazard_ctrl.sv
// rtl/jr_hazard_ctrl.sv - decode-stage jr hazard FSM, redirect flush and saturating stall counter
module jr_hazard_ctrl #(
    parameter int               REG_W    = 5,
    parameter int               OPF_W    = 6,
    parameter logic [OPF_W-1:0] JR_FUNCT = 6'b001000,
    parameter int               PERF_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPF_W-1:0]  opcodeD,
    input  logic [OPF_W-1:0]  functD,
    input  logic [REG_W-1:0]  rsD,
    input  logic [REG_W-1:0]  rdE,
    input  logic              regWriteE,
    input  logic              memReadE,
    input  logic [REG_W-1:0]  rdM,
    input  logic              regWriteM,
    input  logic              memReadM,
    input  logic [REG_W-1:0]  rdW,
    input  logic              regWriteW,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              flushD,
    output logic [1:0]        jrFwdSel,
    output logic [PERF_W-1:0] jrStallCnt
);
    import jr_hazard_ctrl_pkg::*;

    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

    logic              is_jr;
    logic [1:0]        need;
    logic [1:0]        fwd_sel;

    logic [0:0]        state_q, state_d;
    logic [NEED_W-1:0] cnt_q, cnt_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic              stall;

    jr_dep_detect #(
        .REG_W    (REG_W),
        .OPF_W    (OPF_W),
        .JR_FUNCT (JR_FUNCT)
    ) u_dep_detect (
        .opcodeD   (opcodeD),
        .functD    (functD),
        .rsD       (rsD),
        .rdE       (rdE),
        .regWriteE (regWriteE),
        .memReadE  (memReadE),
        .rdM       (rdM),
        .regWriteM (regWriteM),
        .memReadM  (memReadM),
        .rdW       (rdW),
        .regWriteW (regWriteW),
        .is_jr     (is_jr),
        .need      (need),
        .fwd_sel   (fwd_sel)
    );

    // The detection cycle in IDLE is itself the first stall cycle, so STALL
    // only covers the remaining need-1 cycles; a one-cycle need never leaves IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_jr && (need != NEED_NONE)) begin
                    stall = 1'b1;
                    if (need > NEED_ONE) begin
                        state_d = ST_STALL;
                        cnt_d   = need - NEED_TWO;
                    end
                end
            end
            ST_STALL: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - NEED_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        perf_d = perf_q;
        if (stall && (perf_q != PERF_MAX)) begin
            perf_d = perf_q + PERF_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            perf_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perf_q  <= perf_d;
        end
    end

    // The held jr in STALL is not re-decoded, so the select and redirect stay quiet there.
    always_comb begin
        stallF     = stall;
        stallD     = stall;
        flushE     = stall;
        flushD     = (state_q == ST_IDLE) && is_jr && !stall;
        jrFwdSel   = ((state_q == ST_IDLE) && !stall) ? fwd_sel : FWD_RF;
        jrStallCnt = perf_q;
    end

endmodule

// File: tb/tb_jr_hazard_ctrl.sv
// tb/tb_jr_hazard_ctrl.sv - scoreboard bench for the decode-stage jr hazard controller
module tb_jr_hazard_ctrl;

    localparam int PW = 3;
    localparam logic [5:0] J = 6'b001000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    opcodeD = '0;
    logic [5:0]    functD = '0;
    logic [4:0]    rsD = '0;
    logic [4:0]    rdE = '0;
    logic          regWriteE = 1'b0;
    logic          memReadE = 1'b0;
    logic [4:0]    rdM = '0;
    logic          regWriteM = 1'b0;
    logic          memReadM = 1'b0;
    logic [4:0]    rdW = '0;
    logic          regWriteW = 1'b0;
    logic          stallF;
    logic          stallD;
    logic          flushE;
    logic          flushD;
    logic [1:0]    jrFwdSel;
    logic [PW-1:0] jrStallCnt;

    typedef struct packed {
        logic          st;
        logic          fd;
        logic [1:0]    sel;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    logic [PW-1:0] model_cnt = '0;
    int            checks = 0;
    int            errors = 0;

    jr_hazard_ctrl #(.PERF_W(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcodeD    (opcodeD),
        .functD     (functD),
        .rsD        (rsD),
        .rdE        (rdE),
        .regWriteE  (regWriteE),
        .memReadE   (memReadE),
        .rdM        (rdM),
        .regWriteM  (regWriteM),
        .memReadM   (memReadM),
        .rdW        (rdW),
        .regWriteW  (regWriteW),
        .stallF     (stallF),
        .stallD     (stallD),
        .flushE     (flushE),
        .flushD     (flushD),
        .jrFwdSel   (jrFwdSel),
        .jrStallCnt (jrStallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("stallF", int'(stallF), int'(e.st));
            chk("stallD", int'(stallD), int'(e.st));
            chk("flushE", int'(flushE), int'(e.st));
            chk("flushD", int'(flushD), int'(e.fd));
            chk("jrFwdSel", int'(jrFwdSel), int'(e.sel));
            chk("jrStallCnt", int'(jrStallCnt), int'(e.cnt));
        end
    end

    task automatic push_exp(input logic es, input logic efd, input logic [1:0] esel);
        exp_t e;
        e.st  = es;
        e.fd  = efd;
        e.sel = esel;
        e.cnt = model_cnt;
        sb_q.push_back(e);
        if (es && (model_cnt != {PW{1'b1}})) model_cnt = model_cnt + 1'b1;
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] re, input logic we, input logic mre,
                        input logic [4:0] rm, input logic wm, input logic mrm,
                        input logic [4:0] rw, input logic ww,
                        input logic es, input logic efd, input logic [1:0] esel);
        @(posedge clk);
        #1;
        rst = 1'b0;
        opcodeD = op; functD = fn; rsD = rs;
        rdE = re; regWriteE = we; memReadE = mre;
        rdM = rm; regWriteM = wm; memReadM = mrm;
        rdW = rw; regWriteW = ww;
        push_exp(es, efd, esel);
    endtask

    task automatic do_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        opcodeD = '0; functD = '0; rsD = '0;
        rdE = '0; regWriteE = 0; memReadE = 0;
        rdM = '0; regWriteM = 0; memReadM = 0;
        rdW = '0; regWriteW = 0;
        model_cnt = '0;
        push_exp(1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_rst();
        step(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        // load-use jr, then async reset while in STALL
        step(0, J, 5,  5, 1, 1,  0, 0, 0,  0, 0,  1, 0, 0);
        do_rst();
        step(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        step(0, J, 3,  0, 0, 0,  0, 0, 0,  0, 0,  0, 1, 0);
        // ALU producer in E: one stall then forward from M
        step(0, J, 5,  5, 1, 0,  0, 0, 0,  0, 0,  1, 0, 0);
        step(0, J, 5,  0, 0, 0,  5, 1, 0,  0, 0,  0, 1, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        // load in E: two stalls then forward from W
        step(0, J, 5,  5, 1, 1,  0, 0, 0,  0, 0,  1, 0, 0);
        step(0, J, 5,  0, 0, 0,  5, 1, 1,  0, 0,  1, 0, 0);
        step(0, J, 5,  0, 0, 0,  0, 0, 0,  5, 1,  0, 1, 2);
        // load in M: one stall then W; ALU in M forwards immediately and beats W
        step(0, J, 5,  0, 0, 0,  5, 1, 1,  0, 0,  1, 0, 0);
        step(0, J, 5,  0, 0, 0,  0, 0, 0,  5, 1,  0, 1, 2);
        step(0, J, 5,  0, 0, 0,  5, 1, 0,  5, 1,  0, 1, 1);
        // $0 never matches, disabled writers never match, non-jr ignored
        step(0, J, 0,  0, 1, 1,  0, 1, 0,  0, 1,  0, 1, 0);
        step(0, J, 7,  0, 0, 0,  7, 0, 0,  0, 0,  0, 1, 0);
        step(0, J, 5,  6, 1, 1,  4, 1, 0,  3, 1,  0, 1, 0);
        step(0, 6'h20, 5,  5, 1, 1,  0, 0, 0,  0, 0,  0, 0, 0);
        step(6'h23, J, 5,  5, 1, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        // repeated load-use jr drives the counter into saturation
        for (int i = 0; i < 3; i++) begin
            step(0, J, 9,  9, 1, 1,  0, 0, 0,  0, 0,  1, 0, 0);
            step(0, J, 9,  0, 0, 0,  9, 1, 1,  0, 0,  1, 0, 0);
            step(0, J, 9,  0, 0, 0,  0, 0, 0,  9, 1,  0, 1, 2);
        end
        step(0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0);
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
